// File: rtl/object_fetch.sv
// Object-memory fetch front end for the render stage: scans NUM_OBJECTS records
// in groups of four, unpacks them into per-slot fields and hands each group over.
module object_fetch #(
  parameter int NUM_OBJECTS  = 128,
  parameter int READ_LATENCY = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  output logic [6:0]         mem_addr_out,
  input  logic [102:0]       mem_data_in,
  input  logic               render_busy_in,
  input  logic               render_done_in,
  output logic               valid_out,
  output logic [3:0]         is_static_out,
  output logic [3:0][6:0]    addresses_out,
  output logic [3:0][1:0]    id_bits_out,
  output logic [3:0][35:0]   params_out,
  output logic [3:0][15:0]   pos_x_out,
  output logic [3:0][15:0]   pos_y_out,
  output logic [3:0][15:0]   vel_x_out,
  output logic [3:0][15:0]   vel_y_out,
  output logic               busy_out,
  output logic               frame_done_out
);

  typedef enum logic [2:0] {IDLE, FETCH, PRESENT, WAIT, DONE} state_t;

  localparam logic [8:0] NUM_W    = 9'(NUM_OBJECTS);
  localparam logic [2:0] RL_W     = 3'(READ_LATENCY);
  localparam logic [2:0] CNT_LAST = 3'(READ_LATENCY + 3);

  state_t     state, state_nxt;
  logic [7:0] base;
  logic [2:0] cnt;
  logic [6:0] addr_hold;

  logic [8:0] issue_addr;
  logic       issue_ok;
  logic       cap_en;
  logic [1:0] cap_slot;
  logic [8:0] cap_addr;
  logic       cap_ok;
  logic       last_group;

  // Reads are issued in the first four FETCH cycles; captures trail them by READ_LATENCY.
  always_comb begin
    issue_addr = {1'b0, base} + {6'd0, cnt};
    issue_ok   = (state == FETCH) && (cnt < 3'd4) && (issue_addr < NUM_W);
    cap_en     = (state == FETCH) && (cnt >= RL_W);
    cap_slot   = 2'(cnt - RL_W);
    cap_addr   = {1'b0, base} + {7'd0, cap_slot};
    cap_ok     = cap_addr < NUM_W;
    last_group = ({1'b0, base} + 9'd4) >= NUM_W;
  end

  assign mem_addr_out = issue_ok ? issue_addr[6:0] : addr_hold;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    valid_out      = 1'b0;
    busy_out       = (state != IDLE);
    frame_done_out = 1'b0;
    case (state)
      IDLE:    if (start_in) state_nxt = FETCH;
      FETCH:   if (cnt == CNT_LAST) state_nxt = PRESENT;
      PRESENT: if (!render_busy_in) begin
                 valid_out = 1'b1;
                 state_nxt = WAIT;
               end
      WAIT:    if (render_done_in) state_nxt = last_group ? DONE : FETCH;
      DONE:    begin
                 frame_done_out = 1'b1;
                 state_nxt      = IDLE;
               end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      base          <= '0;
      cnt           <= '0;
      addr_hold     <= '0;
      is_static_out <= '0;
      addresses_out <= '0;
      id_bits_out   <= '0;
      params_out    <= '0;
      pos_x_out     <= '0;
      pos_y_out     <= '0;
      vel_x_out     <= '0;
      vel_y_out     <= '0;
    end else begin
      case (state)
        IDLE:  if (start_in) begin
                 base <= '0;
                 cnt  <= '0;
               end
        FETCH: cnt <= cnt + 3'd1;
        WAIT:  if (render_done_in && !last_group) begin
                 base <= base + 8'd4;
                 cnt  <= '0;
               end
        default: ;
      endcase

      if (issue_ok) addr_hold <= issue_addr[6:0];

      // Slots past NUM_OBJECTS were never read; they load zeros but keep their address.
      if (cap_en) begin
        addresses_out[cap_slot] <= cap_addr[6:0];
        if (cap_ok) begin
          is_static_out[cap_slot] <= mem_data_in[102];
          id_bits_out[cap_slot]   <= mem_data_in[101:100];
          params_out[cap_slot]    <= mem_data_in[99:64];
          pos_x_out[cap_slot]     <= mem_data_in[63:48];
          pos_y_out[cap_slot]     <= mem_data_in[47:32];
          vel_x_out[cap_slot]     <= mem_data_in[31:16];
          vel_y_out[cap_slot]     <= mem_data_in[15:0];
        end else begin
          is_static_out[cap_slot] <= 1'b0;
          id_bits_out[cap_slot]   <= '0;
          params_out[cap_slot]    <= '0;
          pos_x_out[cap_slot]     <= '0;
          pos_y_out[cap_slot]     <= '0;
          vel_x_out[cap_slot]     <= '0;
          vel_y_out[cap_slot]     <= '0;
        end
      end
    end
  end

endmodule

// File: doc/object_fetch.md
Name: object_fetch

Overview:
- Upstream feeder for the render stage.
- On a frame-start pulse, scans the object memory in groups of four records and unpacks each record into per-slot fields (is_static, id_bits, params, pos/vel, address).
- Presents each group with a one-cycle valid pulse, then waits for render completion before fetching the next group.
- Signals frame completion after the last group.

Parameters:
- NUM_OBJECTS, 128: object slots scanned per frame, 1..128. The address space is 7-bit.
- READ_LATENCY, 2: object-memory read latency in cycles, 1..4.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  frame-start pulse
- mem_addr_out  output  7  object-memory read address
- mem_data_in  input  103  record; layout {is_static[102], id_bits[101:100], params[99:64], pos_x[63:48], pos_y[47:32], vel_x[31:16], vel_y[15:0]}
- render_busy_in  input  1  render stage busy
- render_done_in  input  1  render valid_out; group finished
- valid_out  output  1  one-cycle pulse, group fields valid
- is_static_out  output  [3:0]  per-slot static flag
- addresses_out  output  [3:0][6:0]  per-slot source address
- id_bits_out  output  [3:0][1:0]  per-slot shape id; 00 = empty
- params_out  output  [3:0][35:0]  per-slot shape params
- pos_x_out, pos_y_out, vel_x_out, vel_y_out  output  [3:0][15:0]  per-slot kinematics
- busy_out  output  1  high whenever state != IDLE
- frame_done_out  output  1  one-cycle pulse after the last group completes

Behaviour:
- Reset: state IDLE, base address 0.
  - All outputs 0, including mem_addr_out, valid_out, busy_out and frame_done_out.
  - Reset mid-operation aborts the scan immediately; no frame_done_out is generated.
- States and transitions:
  - IDLE -> FETCH on start_in.
  - FETCH -> PRESENT after 4+READ_LATENCY cycles.
  - PRESENT -> WAIT when render_busy_in is low; valid_out is pulsed in that same cycle.
  - WAIT -> FETCH on render_done_in, with base += 4, if base+4 < NUM_OBJECTS.
  - WAIT -> DONE on render_done_in otherwise.
  - DONE -> IDLE after one cycle; frame_done_out = 1 in DONE.
- FETCH timing:
  - The k-th FETCH cycle (k=0..3) drives mem_addr_out = base+k.
  - Data for the address issued at cycle c is captured from mem_data_in at c+READ_LATENCY into slot k.
  - Outside FETCH, mem_addr_out holds its last value.
- Latency: with render_busy_in low, valid_out asserts exactly 5+READ_LATENCY cycles after the cycle start_in is sampled (7 at default).
- Output stability:
  - Slot registers change only on capture cycles.
  - All fields are stable from valid_out through the end of WAIT.
  - addresses_out[k] = base+k for every slot, including padded slots.
- Partial last group:
  - Slots with base+k >= NUM_OBJECTS issue no read; mem_addr_out stays at the last valid address.
  - Such slots are captured as all-zero fields, so id_bits = 00.
  - FETCH duration is unchanged.
- Handshake rules:
  - start_in is ignored while busy_out = 1.
  - render_done_in is ignored outside WAIT.
  - render_busy_in high in PRESENT stalls with no pulse; fields are held.
  - start_in and frame_done_out in the same cycle: start_in ignored, since the block is still busy in DONE.
- Arithmetic: base is 8-bit internally so that base+4 does not wrap at 128; mem_addr_out takes base[6:0]+k.

Test Plan:
- Reset then start_in, NUM_OBJECTS=8, READ_LATENCY=2, memory[a] = pattern with pos_x = a, id = 01, render_busy_in = 0, render_done_in 3 cycles after each valid_out:
  - first valid_out 7 cycles after start;
  - pos_x_out = {3,2,1,0}, addresses_out = {3,2,1,0};
  - second group {7,6,5,4};
  - frame_done_out pulses once, busy_out then drops.
- NUM_OBJECTS=6:
  - second group slots 2,3 have id_bits = 00, all fields 0, addresses_out = {7,6,5,4};
  - mem_addr_out never exceeds 5.
- render_busy_in held high 10 cycles on entering PRESENT -> no valid_out during the stall; valid_out pulses in the first cycle busy is low, fields unchanged.
- start_in pulsed during WAIT, and render_done_in pulsed during FETCH -> both ignored; group sequence and valid_out count unchanged.
- rst_in asserted in FETCH of the second group -> next cycle all outputs 0 and state IDLE, with no frame_done_out; a new start_in restarts from address 0.
- READ_LATENCY=4 with unique per-address records -> slot k captures the record of base+k, with no off-by-one; valid_out 9 cycles after start.
